// File: rtl/mat_mult_sched_if.sv
// Handshake bundle between the requesters, the mat_mult engine and the scheduler.
// master = scheduler side, slave = requester/engine side.
interface mat_mult_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = 2
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] done;
    logic [SEL_W-1:0]   eng_sel;
    logic               eng_en;
    logic               eng_done;
    logic               busy;
    logic               err;

    modport master (
        input  req, eng_done,
        output gnt, done, eng_sel, eng_en, busy, err
    );

    modport slave (
        output req, eng_done,
        input  gnt, done, eng_sel, eng_en, busy, err
    );
endinterface

// File: rtl/mat_mult_sched.sv
// Round-robin scheduler sharing one mat_mult engine among NUM_REQ requesters.
// Optional WAIT-state watchdog enabled by defining MAT_MULT_SCHED_TIMEOUT_EN.
module mat_mult_sched #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    mat_mult_sched_if.master  bus
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1 || (1 << SEL_W) < NUM_REQ) begin : g_bad_cfg
        $error("mat_mult_sched: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   ptr, ptr_nxt;
    logic [SEL_W-1:0]   sel, sel_nxt;
    logic [NUM_REQ-1:0] gnt, gnt_nxt;
    logic [NUM_REQ-1:0] done, done_nxt;
    logic               eng_en, eng_en_nxt;
    logic               busy, busy_nxt;
    logic               timeout_hit;

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic                 found;
    logic [SEL_W-1:0]     pick;
    int                   off;
    int                   sum;

    // Rotate requests so bit 0 is the pointer position; first set bit wins.
    always_comb begin
        req_dbl = {bus.req, bus.req} >> ptr;
        req_rot = req_dbl[NUM_REQ-1:0];
        found   = 1'b0;
        off     = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req_rot[j]) begin
                found = 1'b1;
                off   = j;
            end
        end
        sum = int'(ptr) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        pick = SEL_W'(sum);
    end

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        sel_nxt    = sel;
        gnt_nxt    = gnt;
        done_nxt   = '0;
        eng_en_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt  = ISSUE;
                    gnt_nxt    = NUM_REQ'(1) << pick;
                    sel_nxt    = pick;
                    eng_en_nxt = 1'b1;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.eng_done || timeout_hit) begin
                    state_nxt = RELEASE;
                    done_nxt  = gnt;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                ptr_nxt   = (sel == SEL_W'(NUM_REQ - 1)) ? '0 : sel + SEL_W'(1);
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            ptr    <= '0;
            sel    <= '0;
            gnt    <= '0;
            done   <= '0;
            eng_en <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            sel    <= sel_nxt;
            gnt    <= gnt_nxt;
            done   <= done_nxt;
            eng_en <= eng_en_nxt;
            busy   <= busy_nxt;
        end
    end

`ifdef MAT_MULT_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;
    logic             err;
    logic             tmo_fire;

    // Counter rests at zero outside WAIT, so it is clear on every WAIT entry.
    assign timeout_hit = (state == WAIT) && (cnt == CNT_W'(TIMEOUT - 1));
    assign tmo_fire    = timeout_hit && !bus.eng_done;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (state != WAIT) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (tmo_fire) begin
                err <= 1'b1;
            end
        end
    end

    assign bus.err = err;
`else
    assign timeout_hit = 1'b0;
    assign bus.err     = 1'b0;
`endif

    assign bus.gnt     = gnt;
    assign bus.done    = done;
    assign bus.eng_sel = sel;
    assign bus.eng_en  = eng_en;
    assign bus.busy    = busy;

endmodule

// File: tb/tb_mat_mult_sched.sv
// Randomized self-checking bench for mat_mult_sched against a transaction-level model.
module tb_mat_mult_sched;
    localparam int N = 4;
`ifdef MAT_MULT_SCHED_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 1024;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    int   ptr_m  = 0;

    always #5 clk = ~clk;

    mat_mult_sched_if #(.NUM_REQ(N), .SEL_W(2)) bus ();

    mat_mult_sched #(.NUM_REQ(N), .SEL_W(2), .TIMEOUT(TMO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
    endtask

    // Winner: first requester at or after the pointer, wrapping.
    function automatic int winner(input int p, input logic [N-1:0] r);
        int k;
        for (int i = 0; i < N; i++) begin
            k = (p + i) % N;
            if (r[k[1:0]]) return k;
        end
        return -1;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_en"}, 32'(bus.eng_en), 32'd0);
        chk({tag, "_sel"}, 32'(bus.eng_sel), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.req = '0;
        bus.eng_done = 1'b0;
        step();
        reset_n = 1'b1;
        ptr_m = 0;
        chk_all_zero("reset");
    endtask

    task automatic run_op(input logic [N-1:0] pat, input int dly, input bit drop, input bit spur);
        int w;
        logic [N-1:0] oh;
        w = winner(ptr_m, pat);
        oh = '0;
        oh[w[1:0]] = 1'b1;
        bus.req = pat;
        step();
        chk("grant", 32'(bus.gnt), 32'(oh));
        chk("eng_sel", 32'(bus.eng_sel), 32'(w));
        chk("eng_en_on", 32'(bus.eng_en), 32'd1);
        chk("busy_on", 32'(bus.busy), 32'd1);
        if (spur) bus.eng_done = 1'b1;
        step();
        bus.eng_done = 1'b0;
        chk("eng_en_off", 32'(bus.eng_en), 32'd0);
        chk("done_early", 32'(bus.done), 32'd0);
        if (drop) bus.req = '0;
        repeat (dly) begin
            step();
            chk("done_in_wait", 32'(bus.done), 32'd0);
            chk("gnt_hold", 32'(bus.gnt), 32'(oh));
            chk("busy_wait", 32'(bus.busy), 32'd1);
        end
        bus.eng_done = 1'b1;
        step();
        bus.eng_done = 1'b0;
        chk("done_pulse", 32'(bus.done), 32'(oh));
        chk("sel_hold", 32'(bus.eng_sel), 32'(w));
        chk("gnt_release", 32'(bus.gnt), 32'(oh));
        chk("err_clean", 32'(bus.err), 32'd0);
        step();
        chk("done_single", 32'(bus.done), 32'd0);
        chk("gnt_clear", 32'(bus.gnt), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
        ptr_m = (w + 1) % N;
    endtask

    initial begin
        logic [N-1:0] pat;
        reset_n = 1'b0;
        bus.req = '0;
        bus.eng_done = 1'b0;
        step();
        do_reset();

        // Single requester, eng_done sampled five edges after the request.
        run_op(4'b0010, 3, 1'b0, 1'b0);

        // Stray eng_done while idle.
        bus.req = '0;
        bus.eng_done = 1'b1;
        step();
        bus.eng_done = 1'b0;
        chk("spur_idle_done", 32'(bus.done), 32'd0);
        chk("spur_idle_busy", 32'(bus.busy), 32'd0);
        step();
        chk("spur_idle_busy2", 32'(bus.busy), 32'd0);

        // Round-robin with all requesters active, including wrap.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            chk("rr_order", 32'(winner(ptr_m, 4'b1111)), 32'(i % N));
            run_op(4'b1111, 1, 1'b0, 1'b0);
        end

        // eng_done during ISSUE ignored; request dropped during WAIT.
        run_op(4'b0100, 2, 1'b1, 1'b1);

        for (int i = 0; i < 30; i++) begin
            pat = 4'($urandom_range(1, 15));
            run_op(pat, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
        end

        // Reset in the middle of WAIT aborts without done.
        bus.req = 4'b0100;
        step();
        step();
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        bus.req = '0;
        ptr_m = 0;
        chk_all_zero("midop_reset");
        bus.eng_done = 1'b1;
        step();
        bus.eng_done = 1'b0;
        chk("late_done", 32'(bus.done), 32'd0);
        chk("late_busy", 32'(bus.busy), 32'd0);
        step();
        chk("late_done2", 32'(bus.done), 32'd0);
        run_op(4'b1010, 0, 1'b0, 1'b0);

`ifdef MAT_MULT_SCHED_TIMEOUT_EN
        // eng_done on the timeout cycle wins.
        bus.req = 4'b1000;
        step();
        step();
        bus.req = '0;
        repeat (TMO - 1) begin
            step();
            chk("coin_wait", 32'(bus.done), 32'd0);
        end
        bus.eng_done = 1'b1;
        step();
        bus.eng_done = 1'b0;
        chk("coin_done", 32'(bus.done), 32'b1000);
        chk("coin_err", 32'(bus.err), 32'd0);
        step();
        chk("coin_idle", 32'(bus.busy), 32'd0);
        ptr_m = 0;

        // Engine never answers.
        bus.req = 4'b0001;
        step();
        step();
        bus.req = '0;
        repeat (TMO - 1) begin
            step();
            chk("tmo_wait", 32'(bus.done), 32'd0);
            chk("tmo_err_low", 32'(bus.err), 32'd0);
        end
        step();
        chk("tmo_done", 32'(bus.done), 32'b0001);
        chk("tmo_err", 32'(bus.err), 32'd1);
        repeat (3) step();
        chk("tmo_sticky", 32'(bus.err), 32'd1);
        chk("tmo_idle", 32'(bus.busy), 32'd0);
        do_reset();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
